// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: CHUNK bits per clock, ripple carry held in a register.
// Results (sum/carry/overflow) load only on the RUN->DONE edge and hold until the next one.
module multicycle_adder #(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int N_STEPS = WIDTH / CHUNK;
  localparam int CW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_step;

  // Handshake: start is accepted only in IDLE or DONE; busy is high while chunks
  // are being added; done is a one-cycle pulse coinciding with fresh results.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    c_d       = c_q;
    w_d       = w_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    a_chunk   = opa_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_chunk   = opb_q[int'(cnt_q)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    last_step = (cnt_q == CW'(N_STEPS - 1));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          c_d     = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        w_d[int'(cnt_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        c_d   = chunk_sum[CHUNK];
        cnt_d = last_step ? '0 : cnt_q + CW'(1);
        if (last_step) begin
          state_d = S_DONE;
          sum_d   = w_d;
          carry_d = chunk_sum[CHUNK];
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (w_d[WIDTH-1] != opa_q[WIDTH-1]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      c_q     <= 1'b0;
      w_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      c_q     <= c_d;
      w_q     <= w_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: default 9/3 instance plus a 16/4 instance, scoreboard
// of {carry, overflow, sum} pushed at start and popped at done.
module tb_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, sub;
  logic [8:0] a, b, sum;
  logic       busy, done, carry, ovf;
  logic [1:0] st;

  logic        start16, sub16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, carry16, ovf16;
  logic [1:0]  st16;

  int vectors     = 0;
  int miscompares = 0;

  logic [10:0] exp_q[$];
  logic [17:0] exp16_q[$];
  logic [10:0] last_exp;

  multicycle_adder #(.WIDTH(9), .CHUNK(3)) dut9 (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .A(a), .B(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(ovf), .dbg_state(st)
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .sub(sub16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16),
    .dbg_state(st16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width add with signed-range overflow, returns {carry, ovf, sum}.
  function automatic logic [10:0] model9(input logic [8:0] x, input logic [8:0] y, input logic s);
    logic [9:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, (s ? ~y : y)} + 10'(s);
    if (s) o = (x[8] != y[8]) && (t[8] != x[8]);
    else   o = (x[8] == y[8]) && (t[8] != x[8]);
    return {t[9], o, t[8:0]};
  endfunction

  // Drive a one-cycle start; afterwards scramble inputs to prove they were latched.
  task automatic go9(input logic [8:0] av, input logic [8:0] bv, input logic sv);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 9'($urandom_range(0, 511));
    b = 9'($urandom_range(0, 511));
    sub = 1'($urandom_range(0, 1));
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait9(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_result"}, 32'({carry, ovf, sum}), 32'(last_exp));
    end
  endtask

  task automatic after_done9(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(st), 32'd0);
    check({tag, "_hold"}, 32'({carry, ovf, sum}), 32'(last_exp));
  endtask

  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic [17:0] e);
    int n;
    logic [17:0] got;
    exp16_q.push_back(e);
    a16 = av; b16 = bv; sub16 = sv; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done16 && n < 20);
    check({tag, "_latency"}, 32'(n), 32'd4);
    got = exp16_q.pop_front();
    check({tag, "_result"}, 32'({carry16, ovf16, sum16}), 32'(got));
    @(posedge clk); #1;
  endtask

  logic [8:0] ra, rb;
  logic       rs;
  logic       saw_done;

  initial begin
    reset_n = 1'b0; start = 1'b1; sub = 1'b0; a = '0; b = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'({carry, ovf, sum}), 32'd0);
    check("rst_state", 32'(st), 32'd0);
    reset_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-derived expectations {carry, ovf, sum}.
    exp_q.push_back({1'b0, 1'b0, 9'h101}); go9(9'h100, 9'h001, 1'b0); wait9("add_basic", 3);  after_done9("add_basic");
    exp_q.push_back({1'b1, 1'b1, 9'h000}); go9(9'h100, 9'h100, 1'b0); wait9("add_msb", 3);    after_done9("add_msb");
    exp_q.push_back({1'b1, 1'b0, 9'h000}); go9(9'h1FF, 9'h001, 1'b0); wait9("add_ripple", 3); after_done9("add_ripple");
    exp_q.push_back({1'b0, 1'b1, 9'h100}); go9(9'h0FF, 9'h001, 1'b0); wait9("add_ovf", 3);    after_done9("add_ovf");
    exp_q.push_back({1'b1, 1'b0, 9'h002}); go9(9'd7, 9'd5, 1'b1);     wait9("sub_pos", 3);    after_done9("sub_pos");
    exp_q.push_back({1'b0, 1'b0, 9'h1FE}); go9(9'd5, 9'd7, 1'b1);     wait9("sub_neg", 3);    after_done9("sub_neg");

    // start pulsed mid-RUN with new operands must be ignored.
    exp_q.push_back({1'b0, 1'b0, 9'h0BB});
    go9(9'h0AA, 9'h011, 1'b0);
    @(posedge clk); #1;
    a = 9'h1FF; b = 9'h1FF; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midrun_busy", 32'(busy), 32'd1);
    wait9("midrun_ignored", 1);
    after_done9("midrun_ignored");

    // Back-to-back: each new start lands in the DONE cycle of the previous op.
    exp_q.push_back(model9(9'h155, 9'h0AB, 1'b0));
    go9(9'h155, 9'h0AB, 1'b0);
    wait9("b2b_first", 3);
    for (int i = 0; i < 8; i++) begin
      ra = 9'($urandom_range(0, 511));
      rb = 9'($urandom_range(0, 511));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model9(ra, rb, rs));
      go9(ra, rb, rs);
      check("b2b_hold_in_run", 32'(sum), 32'(last_exp[8:0]));
      wait9("b2b_rand", 3);
    end
    after_done9("b2b_tail");

    // Reset mid-RUN aborts: no done pulse, outputs cleared.
    go9(9'h123, 9'h045, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_outs", 32'({busy, done, carry, ovf, sum}), 32'd0);
    check("abort_state", 32'(st), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    // Wider configuration: 16 bits in 4-bit chunks.
    run16("w16_wrap",  16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000});
    run16("w16_ovf",   16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000});
    run16("w16_sub",   16'h0003, 16'h0005, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    run16("w16_subov", 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
